// File: rtl/ipf_pkg.sv
// ipf_pkg: shared command/state encodings and width helper for ipf_ring
package ipf_pkg;
   localparam logic [1:0] CTRL_END   = 2'd0;
   localparam logic [1:0] CTRL_START = 2'd1;
   localparam logic [1:0] CTRL_HOLD  = 2'd2;
   typedef enum logic [1:0] {WAIT, COMPUTE, FINISH} state_t;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/ipf_slice_mul.sv
// ipf_slice_mul: one lane, {a*w_lo, b*w_hi} with full-width unsigned products
module ipf_slice_mul #(
   parameter int SLICE = 2
) (
   input  logic [SLICE-1:0]   a,
   input  logic [SLICE-1:0]   b,
   input  logic [2*SLICE-1:0] w,
   output logic [4*SLICE-1:0] p
);
   localparam int PW = 2 * SLICE;
   logic [PW-1:0] lo_p;
   logic [PW-1:0] hi_p;
   assign lo_p = PW'(a) * PW'(w[SLICE-1:0]);
   assign hi_p = PW'(b) * PW'(w[2*SLICE-1:SLICE]);
   assign p    = {lo_p, hi_p};
endmodule

// File: rtl/ipf_ring.sv
// ipf_ring: ring of input rows rotated past LANES slice multipliers against one weight word
module ipf_ring
   import ipf_pkg::*;
#(
   parameter int  LANES = 4,
   parameter int  SLICE = 2,
   parameter int  ROWS  = 3,
   localparam int ROW_W = LANES * SLICE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               ctrl,
   input  logic [ROW_W-1:0]         i_data,
   input  logic                     i_valid,
   output logic                     i_ready,
   input  logic [2*SLICE-1:0]       w_data,
   input  logic                     w_valid,
   output logic [LANES*4*SLICE-1:0] res,
   output logic                     res_valid,
   output logic                     pass_done,
   output logic                     finish
);
   localparam int            CW   = cnt_w(ROWS);
   localparam logic [CW-1:0] FULL = CW'(ROWS);
   localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

   state_t                   state;
   state_t                   state_nx;
   logic [ROW_W-1:0]         row [ROWS];
   logic [2*SLICE-1:0]       weight;
   logic [CW-1:0]            fill_cnt;
   logic [CW-1:0]            rot_cnt;
   logic                     w_loaded;
   logic                     do_comp;
   logic                     last;
   logic                     load;
   logic [LANES*4*SLICE-1:0] lane_res;

   assign i_ready = (state == WAIT);
   assign finish  = (state == FINISH);
   assign last    = (rot_cnt == LAST);
   assign load    = i_ready & i_valid;

   genvar k;
   for (k = 0; k < LANES; k++) begin : g_lane
      ipf_slice_mul #(.SLICE(SLICE)) u_mul (
         .a (row[0][k*SLICE +: SLICE]),
         .b (row[1][k*SLICE +: SLICE]),
         .w (weight),
         .p (lane_res[k*4*SLICE +: 4*SLICE])
      );
   end

   // Next state and compute-edge decode; END wins over everything
   always_comb begin
      state_nx = state;
      do_comp  = 1'b0;
      if (ctrl == CTRL_END)
         state_nx = FINISH;
      else if (state == WAIT && ctrl == CTRL_START && fill_cnt == FULL && w_loaded)
         state_nx = COMPUTE;
      else if (state == COMPUTE && ctrl == CTRL_HOLD)
         state_nx = WAIT;
      else if (state == COMPUTE) begin
         do_comp  = 1'b1;
         state_nx = last ? WAIT : COMPUTE;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst)
         state <= WAIT;
      else
         state <= state_nx;
   end

   // Ring: shift a new row in while waiting, rotate oldest to the back while computing
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int j = 0; j < ROWS; j++) row[j] <= '0;
      end else if (do_comp || load) begin
         for (int j = 0; j < ROWS - 1; j++) row[j] <= row[j+1];
         row[ROWS-1] <= do_comp ? row[0] : i_data;
      end
   end

   // Fill/rotation counters and weight; a fresh row restarts the pass from the top
   always_ff @(posedge clk) begin
      if (!rst) begin
         fill_cnt <= '0;
         rot_cnt  <= '0;
         weight   <= '0;
         w_loaded <= 1'b0;
      end else begin
         if (do_comp)
            rot_cnt <= last ? '0 : rot_cnt + 1'b1;
         if (load) begin
            fill_cnt <= (fill_cnt == FULL) ? FULL : fill_cnt + 1'b1;
            rot_cnt  <= '0;
         end
         if (i_ready && w_valid) begin
            weight   <= w_data;
            w_loaded <= 1'b1;
         end
      end
   end

   // Registered results; res holds its value outside compute edges
   always_ff @(posedge clk) begin
      if (!rst) begin
         res       <= '0;
         res_valid <= 1'b0;
         pass_done <= 1'b0;
      end else begin
         res_valid <= do_comp;
         pass_done <= do_comp && last;
         if (do_comp)
            res <= lane_res;
      end
   end
endmodule

// File: tb/tb_ipf_ring.sv
// tb_ipf_ring: directed test-plan sequences plus random traffic against a queue-based reference model
module tb_ipf_ring;
   localparam int ROWS = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ctrl;
   logic [7:0]  i_data;
   logic        i_valid;
   logic        i_ready;
   logic [3:0]  w_data;
   logic        w_valid;
   logic [31:0] res;
   logic        res_valid;
   logic        pass_done;
   logic        finish;

   int n_vec = 0;
   int n_err = 0;

   int          q[$];
   int          m_w;
   bit          m_wok;
   int          m_rot;
   int          m_st;
   logic [31:0] e_res;
   bit          e_rv;
   bit          e_pd;

   always #5 clk = ~clk;

   ipf_ring dut (
      .clk       (clk),
      .rst       (rst),
      .ctrl      (ctrl),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .w_data    (w_data),
      .w_valid   (w_valid),
      .res       (res),
      .res_valid (res_valid),
      .pass_done (pass_done),
      .finish    (finish)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] lanes(input int r0, input int r1, input int w);
      logic [31:0] v = 32'd0;
      for (int k = 0; k < 4; k++) begin
         int a = (r0 >> (2 * k)) & 3;
         int b = (r1 >> (2 * k)) & 3;
         int p = ((a * (w & 3)) << 4) | (b * ((w >> 2) & 3));
         v = v | (32'(p) << (8 * k));
      end
      return v;
   endfunction

   // Model state: 0 = waiting, 1 = computing, 2 = finished
   task automatic model(input logic r, input logic [1:0] c, input logic iv, input logic [7:0] id,
                        input logic wv, input logic [3:0] wd);
      int nst;
      e_rv = 0;
      e_pd = 0;
      if (!r) begin
         q.delete();
         m_w = 0; m_wok = 0; m_rot = 0; m_st = 0; e_res = 32'd0;
         return;
      end
      nst = m_st;
      if (c == 2'd0)
         nst = 2;
      else if (m_st == 0 && c == 2'd1 && q.size() == ROWS && m_wok)
         nst = 1;
      else if (m_st == 1 && c == 2'd2)
         nst = 0;
      else if (m_st == 1) begin
         e_rv  = 1;
         e_res = lanes(q[0], q[1], m_w);
         q.push_back(q.pop_front());
         m_rot++;
         if (m_rot == ROWS) begin
            e_pd  = 1;
            m_rot = 0;
            nst   = 0;
         end
      end
      if (m_st == 0 && iv) begin
         q.push_back(int'(id));
         if (q.size() > ROWS) void'(q.pop_front());
         m_rot = 0;
      end
      if (m_st == 0 && wv) begin
         m_w   = int'(wd);
         m_wok = 1;
      end
      m_st = nst;
   endtask

   task automatic cycle(input logic r, input logic [1:0] c, input logic iv, input logic [7:0] id,
                        input logic wv, input logic [3:0] wd);
      rst = r; ctrl = c; i_valid = iv; i_data = id; w_valid = wv; w_data = wd;
      @(posedge clk);
      model(r, c, iv, id, wv, wd);
      #1;
      chk("res", res, e_res);
      chk("res_valid", {31'd0, res_valid}, {31'd0, e_rv});
      chk("pass_done", {31'd0, pass_done}, {31'd0, e_pd});
      chk("finish", {31'd0, finish}, {31'd0, m_st == 2});
      chk("i_ready", {31'd0, i_ready}, {31'd0, m_st == 0});
   endtask

   task automatic nop(input logic iv);
      cycle(1'b1, 2'd3, iv, 8'hA7, 1'b0, 4'h0);
   endtask

   task automatic start(input logic iv);
      cycle(1'b1, 2'd1, iv, 8'h00, 1'b0, 4'h0);
   endtask

   task automatic do_reset();
      cycle(1'b0, 2'd1, 1'b1, 8'hFF, 1'b1, 4'hF);
      cycle(1'b0, 2'd1, 1'b1, 8'hFF, 1'b1, 4'hF);
   endtask

   task automatic load_std();
      cycle(1'b1, 2'd3, 1'b1, 8'h1B, 1'b0, 4'h0);
      cycle(1'b1, 2'd3, 1'b1, 8'hE4, 1'b0, 4'h0);
      cycle(1'b1, 2'd3, 1'b1, 8'h55, 1'b1, 4'h9);
   endtask

   task automatic pass_std(input logic iv);
      start(1'b0);
      nop(iv); chk("pass_r0", res, 32'h06142230);
      nop(iv); chk("pass_r1", res, 32'h32221202);
      nop(iv); chk("pass_r2", res, 32'h10121416); chk("pass_pd", {31'd0, pass_done}, 32'd1);
      chk("pass_rdy", {31'd0, i_ready}, 32'd1);
   endtask

   initial begin
      // reset with loads and START offered: nothing must be taken
      do_reset();
      nop(1'b0);
      chk("idle_res", res, 32'd0);
      chk("idle_rdy", {31'd0, i_ready}, 32'd1);
      start(1'b0);
      nop(1'b0);
      chk("idle_nostart", {31'd0, res_valid}, 32'd0);
      // full pass
      load_std();
      pass_std(1'b0);
      // not ready: two rows plus weight, START ignored
      do_reset();
      cycle(1'b1, 2'd3, 1'b1, 8'h1B, 1'b0, 4'h0);
      cycle(1'b1, 2'd3, 1'b1, 8'hE4, 1'b1, 4'h9);
      start(1'b0);
      nop(1'b0);
      chk("nr_rv", {31'd0, res_valid}, 32'd0);
      chk("nr_rdy", {31'd0, i_ready}, 32'd1);
      cycle(1'b1, 2'd3, 1'b1, 8'h55, 1'b0, 4'h0);
      pass_std(1'b0);
      // hold and resume
      start(1'b0);
      nop(1'b0); chk("hr_r0", res, 32'h06142230);
      cycle(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 4'h0);
      chk("hr_rv", {31'd0, res_valid}, 32'd0);
      chk("hr_rdy", {31'd0, i_ready}, 32'd1);
      start(1'b0);
      nop(1'b0); chk("hr_r1", res, 32'h32221202);
      nop(1'b0); chk("hr_r2", res, 32'h10121416); chk("hr_pd", {31'd0, pass_done}, 32'd1);
      // back-pressure: i_valid during COMPUTE must not disturb the ring
      pass_std(1'b1);
      pass_std(1'b0);
      // END mid-pass, sticky until reset
      start(1'b0);
      nop(1'b0);
      cycle(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 4'h0);
      chk("end_fin", {31'd0, finish}, 32'd1);
      chk("end_rv", {31'd0, res_valid}, 32'd0);
      chk("end_rdy", {31'd0, i_ready}, 32'd0);
      for (int i = 0; i < 4; i++) start(1'b1);
      chk("end_sticky", {31'd0, finish}, 32'd1);
      do_reset();
      nop(1'b0);
      chk("end_recover", {31'd0, finish}, 32'd0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         int x = int'($urandom_range(0, 63));
         logic [1:0] c = (x == 0) ? 2'd0 : (x < 24) ? 2'd1 : (x < 32) ? 2'd2 : 2'd3;
         logic r = ($urandom_range(0, 99) != 0);
         cycle(r, c, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
